// File: rtl/mem_dma_pkg.sv
// mem_dma_pkg: state encoding and default address width shared by the DMA copy engine
package mem_dma_pkg;
   localparam int DMA_ADDR_WIDTH = 14;
   typedef enum logic [2:0] {S_IDLE, S_FILL, S_RUN, S_DRAIN, S_DONE} state_t;
endpackage

// File: rtl/dma_word_counter.sv
// dma_word_counter: loadable down-counter of words still to be read, with zero and last flags
// Ports: clk, rst (sync, active high), load/load_val (preset), dec (count down, saturates at 0),
//        zero (count==0), last (count==1)
module dma_word_counter #(
   parameter int W = 13
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         dec,
   output logic         zero,
   output logic         last
);
   logic [W-1:0] count;
   always_ff @(posedge clk)
      if (rst) count <= '0;
      else if (load) count <= load_val;
      else if (dec && !zero) count <= count - W'(1);
   assign zero = count == '0;
   assign last = count == W'(1);
endmodule

// File: rtl/mem_copy_dma.sv
// mem_copy_dma: block copy of 32-bit words inside one word memory, one word per cycle
// Ports: clk, rst (sync, active high); start with src_addr/dst_addr/len (len 0..2**(ADDR_WIDTH-2));
//        busy, done (one-cycle pulse); read port Raddr/Rden/Rdata (Rdata combinational);
//        write port Waddr/Wren/Wdata; checksum (sum of written words) only with DMA_CHECKSUM_EN.
// All outputs are registered; Raddr doubles as the read pointer, Waddr as the write pointer
// and Wdata as the pipeline data register, so they hold their last value when idle.
module mem_copy_dma
   import mem_dma_pkg::*;
#(
   parameter int ADDR_WIDTH = DMA_ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-3:0] src_addr,
   input  logic [ADDR_WIDTH-3:0] dst_addr,
   input  logic [ADDR_WIDTH-2:0] len,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-3:0] Raddr,
   output logic                  Rden,
   input  logic [31:0]           Rdata,
   output logic [ADDR_WIDTH-3:0] Waddr,
   output logic                  Wren,
   output logic [31:0]           Wdata
`ifdef DMA_CHECKSUM_EN
   ,
   output logic [31:0]           checksum
`endif
);
   localparam int AW = ADDR_WIDTH - 2;
   localparam int LW = ADDR_WIDTH - 1;
   state_t state;
   logic accept, zero, last;
   assign accept = state == S_IDLE && start;
   // remaining counts reads still to issue after the FILL read
   dma_word_counter #(.W(LW)) u_cnt (
      .clk,
      .rst,
      .load(accept && len != '0),
      .load_val(len - LW'(1)),
      .dec(state == S_RUN),
      .zero,
      .last
   );
   always_ff @(posedge clk)
      if (rst) begin
         state <= S_IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         Rden  <= 1'b0;
         Wren  <= 1'b0;
         Raddr <= '0;
         Waddr <= '0;
         Wdata <= '0;
      end else
         case (state)
            S_IDLE:
               if (start) begin
                  if (len == '0) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_FILL;
                     busy  <= 1'b1;
                     Rden  <= 1'b1;
                     Raddr <= src_addr;
                     Waddr <= dst_addr;
                  end
               end
            S_FILL: begin
               Wdata <= Rdata;
               Wren  <= 1'b1;
               if (!zero) begin
                  state <= S_RUN;
                  Raddr <= Raddr + AW'(1);
               end else begin
                  state <= S_DRAIN;
                  Rden  <= 1'b0;
               end
            end
            S_RUN: begin
               Wdata <= Rdata;
               Waddr <= Waddr + AW'(1);
               // last read of the block happens in this cycle
               if (last) begin
                  state <= S_DRAIN;
                  Rden  <= 1'b0;
               end else
                  Raddr <= Raddr + AW'(1);
            end
            S_DRAIN: begin
               state <= S_DONE;
               Wren  <= 1'b0;
               busy  <= 1'b0;
               done  <= 1'b1;
            end
            S_DONE: begin
               state <= S_IDLE;
               done  <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
`ifdef DMA_CHECKSUM_EN
   always_ff @(posedge clk)
      if (rst || accept) checksum <= '0;
      else if (Wren) checksum <= checksum + Wdata;
`endif
endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: random and directed block copies against a snapshot-copy memory model
module tb_mem_copy_dma;
   localparam int MW = 4096;
   typedef struct {int c; logic [11:0] a; logic [31:0] d;} wr_t;
   typedef struct {int c; logic [31:0] sum;} dn_t;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [11:0] src_addr = '0, dst_addr = '0;
   logic [12:0] len = '0;
   logic busy, done, Rden, Wren;
   logic [11:0] Raddr, Waddr;
   logic [31:0] Rdata, Wdata;
`ifdef DMA_CHECKSUM_EN
   logic [31:0] checksum;
`endif
   logic [31:0] mem [MW];
   logic [31:0] ref_mem [MW];
   logic tb_we = 1'b0;
   logic [11:0] tb_a = '0;
   logic [31:0] tb_d = '0;
   int cyc = 0, n_cmp = 0, n_bad = 0;
   wr_t exp_wr[$];
   dn_t exp_done[$];
   wr_t w;
   dn_t e;

   mem_copy_dma dut (
      .clk(clk), .rst(rst), .start(start), .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
      .busy(busy), .done(done), .Raddr(Raddr), .Rden(Rden), .Rdata(Rdata),
      .Waddr(Waddr), .Wren(Wren), .Wdata(Wdata)
`ifdef DMA_CHECKSUM_EN
      , .checksum(checksum)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   assign Rdata = mem[Raddr];
   always @(posedge clk)
      if (Wren) mem[Waddr] <= Wdata;
      else if (tb_we) mem[tb_a] <= tb_d;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // scoreboard monitor: every write and done pulse must match the head of its queue
   always @(negedge clk) begin
      if (Wren) begin
         if (exp_wr.size() == 0) chk("unexpected_write", 64'(Waddr), 64'hffff);
         else begin
            w = exp_wr.pop_front();
            chk("wr_cycle", 64'(cyc), 64'(w.c));
            chk("wr_addr", 64'(Waddr), 64'(w.a));
            chk("wr_data", 64'(Wdata), 64'(w.d));
         end
      end
      if (done) begin
         if (exp_done.size() == 0) chk("unexpected_done", 64'(done), 64'(0));
         else begin
            e = exp_done.pop_front();
            chk("done_cycle", 64'(cyc), 64'(e.c));
`ifdef DMA_CHECKSUM_EN
            chk("checksum", 64'(checksum), 64'(e.sum));
`endif
         end
      end
   end

   task automatic poke(input int a, input logic [31:0] d);
      @(negedge clk);
      tb_we = 1'b1;
      tb_a = 12'(a);
      tb_d = d;
      ref_mem[a] = d;
      @(posedge clk);
      #1 tb_we = 1'b0;
   endtask

   task automatic mem_chk(input string nm);
      int bad = 0;
      for (int i = 0; i < MW; i++) if (mem[i] !== ref_mem[i]) bad++;
      chk(nm, 64'(bad), 64'(0));
   endtask

   // returns sc such that cycle n after acceptance has cyc == sc + n
   task automatic accept(input int s, input int d, input int l, output int sc);
      @(negedge clk);
      src_addr = 12'(s);
      dst_addr = 12'(d);
      len = 13'(l);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      sc = cyc - 1;
   endtask

   // model: the block is read as a snapshot of the source, then written in order
   task automatic run_copy(input int s, input int d, input int l, input bit glitch);
      int sc, dn;
      logic [31:0] sum = '0;
      logic [31:0] snap[$];
      for (int k = 0; k < l; k++) snap.push_back(ref_mem[(s + k) % MW]);
      accept(s, d, l, sc);
      for (int k = 0; k < l; k++) begin
         ref_mem[(d + k) % MW] = snap[k];
         sum += snap[k];
         exp_wr.push_back('{sc + k + 2, 12'((d + k) % MW), snap[k]});
      end
      dn = (l == 0) ? 1 : l + 2;
      exp_done.push_back('{sc + dn, sum});
      for (int n = 1; n <= dn + 1; n++) begin
         @(negedge clk);
         if (glitch) begin
            start = n >= 2 && n <= dn;
            len = 13'd7;
            src_addr = 12'($urandom);
            dst_addr = 12'($urandom);
         end
         chk("busy", 64'(busy), 64'(l != 0 && n <= l + 1));
         chk("rden", 64'(Rden), 64'(l != 0 && n <= l));
         if (l != 0 && n <= l) chk("raddr", 64'(Raddr), 64'((s + n - 1) % MW));
      end
      start = 1'b0;
      chk("wr_pending", 64'(exp_wr.size()), 64'(0));
      chk("done_pending", 64'(exp_done.size()), 64'(0));
      mem_chk("mem_after_copy");
   endtask

   task automatic run_abort(input int s, input int d);
      int sc;
      accept(s, d, 8, sc);
      for (int k = 0; k < 2; k++) begin
         exp_wr.push_back('{sc + k + 2, 12'((d + k) % MW), ref_mem[(s + k) % MW]});
         ref_mem[(d + k) % MW] = ref_mem[(s + k) % MW];
      end
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_wren", 64'(Wren), 64'(0));
      chk("abort_rden", 64'(Rden), 64'(0));
      repeat (12) @(negedge clk);
      chk("abort_wr_pending", 64'(exp_wr.size()), 64'(0));
      mem_chk("mem_after_abort");
   endtask

   initial begin
      int s, d, l, off;
      repeat (2) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_rden", 64'(Rden), 64'(0));
      chk("rst_wren", 64'(Wren), 64'(0));
      chk("rst_raddr", 64'(Raddr), 64'(0));
      chk("rst_waddr", 64'(Waddr), 64'(0));
      chk("rst_wdata", 64'(Wdata), 64'(0));
`ifdef DMA_CHECKSUM_EN
      chk("rst_checksum", 64'(checksum), 64'(0));
`endif
      rst = 1'b0;
      for (int i = 0; i < MW; i++) poke(i, $urandom);
      poke(138, 32'h2); poke(139, 32'hc); poke(140, 32'he); poke(141, 32'h6);
      run_copy(138, 200, 4, 1'b0);
      chk("dir_200", 64'(mem[200]), 64'h2);
      chk("dir_203", 64'(mem[203]), 64'h6);
      run_copy(77, 900, 0, 1'b0);
      run_copy(4094, 10, 4, 1'b0);
      run_copy(50, 51, 3, 1'b0);
      run_copy(700, 1000, 1, 1'b0);
      run_abort(600, 1500);
      run_copy(600, 1500, 8, 1'b0);
      poke(300, 32'h1); poke(301, 32'h2); poke(302, 32'h3); poke(303, 32'hffffffff);
      run_copy(300, 400, 4, 1'b1);
      for (int t = 0; t < 30; t++) begin
         do begin
            s = $urandom_range(0, MW - 1);
            d = $urandom_range(0, MW - 1);
            l = $urandom_range(0, 40);
            off = (d - s + MW) % MW;
         end while (off >= 2 && off < l);
         run_copy(s, d, l, t % 5 == 0);
      end
      s = $urandom_range(0, MW - 1);
      run_copy(s, (s + 1) % MW, MW, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
